// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: control, ROM and IF/ID bundle for the fetch stage.
interface instr_fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] rom_pc;
  logic [31:0] rom_instr;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_done;
  logic [15:0] fetch_count;
  modport master (
    input  stall, flush, branch_taken, branch_target, rom_instr,
    output rom_pc, if_id_pc_plus4, if_id_instr, if_id_valid, fetch_done, fetch_count
  );
  modport slave (
    output stall, flush, branch_taken, branch_target, rom_instr,
    input  rom_pc, if_id_pc_plus4, if_id_instr, if_id_valid, fetch_done, fetch_count
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC register and IF/ID pipeline register with stall, flush and branch redirect.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] END_PC   = 32'd48
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_stage_if.master bus
);
  logic [31:0] pc, pc_plus4, pc4_q, instr_q;
  logic        valid_q, done;
  logic [15:0] cnt_q;
  assign pc_plus4            = pc + 32'd4;
  assign done                = pc >= END_PC;
  assign bus.rom_pc          = pc;
  assign bus.fetch_done      = done;
  assign bus.if_id_pc_plus4  = pc4_q;
  assign bus.if_id_instr     = instr_q;
  assign bus.if_id_valid     = valid_q;
  assign bus.fetch_count     = cnt_q;
  // Branch and flush both override stall; beyond the image the ROM word is never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      pc4_q   <= 32'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else if (bus.branch_taken) begin
      pc      <= {bus.branch_target[31:2], 2'b00};
      pc4_q   <= pc_plus4;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      pc      <= done ? pc : pc_plus4;
      pc4_q   <= pc_plus4;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc      <= done ? pc : pc_plus4;
      pc4_q   <= pc_plus4;
      instr_q <= done ? 32'd0 : bus.rom_instr;
      valid_q <= !done;
      if (!done && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed and randomized checks of the fetch stage against a transaction-level model.
module tb_instr_fetch_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] rom [0:11];
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  int          m_cnt;

  instr_fetch_stage_if bus();
  instr_fetch_stage #(.RESET_PC(32'd0), .END_PC(32'd48)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a < 32'd48) ? rom[a / 4] : 32'hDEADBEEF;
  endfunction

  assign bus.rom_instr = rom_word(bus.rom_pc);

  // Model: one fetch-slot transaction per edge, decided by the highest-priority request present.
  task automatic model_edge();
    bit done = (m_pc >= 32'd48);
    if (bus.branch_taken) begin
      m_pc4 = m_pc + 4; m_instr = 0; m_valid = 0;
      m_pc = bus.branch_target & ~32'd3;
    end else if (bus.flush) begin
      m_pc4 = m_pc + 4; m_instr = 0; m_valid = 0;
      if (!done) m_pc = m_pc + 4;
    end else if (!bus.stall) begin
      m_pc4 = m_pc + 4;
      m_instr = done ? 32'd0 : rom_word(m_pc);
      m_valid = !done;
      if (!done) begin
        m_pc = m_pc + 4;
        m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.branch_target = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    rst_n = 1;
    m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_cnt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    n_cmp++;
    if (bus.rom_pc !== 32'd0 || bus.if_id_pc_plus4 !== 32'd0 || bus.if_id_instr !== 32'd0 ||
        bus.if_id_valid !== 1'b0 || bus.fetch_count !== 16'd0 || bus.fetch_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: pc=%h pc4=%h instr=%h valid=%b cnt=%0d done=%b, want all zero",
               bus.rom_pc, bus.if_id_pc_plus4, bus.if_id_instr, bus.if_id_valid, bus.fetch_count, bus.fetch_done);
    end
  endtask

  task automatic test_straight_run();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++;
      if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_plus4 !== 32'(4 * i) || bus.if_id_instr !== rom[i - 1]) begin
        n_bad++;
        $display("FAIL straight_%0d: valid=%b pc4=%h instr=%h, want 1 %h %h",
                 i, bus.if_id_valid, bus.if_id_pc_plus4, bus.if_id_instr, 32'(4 * i), rom[i - 1]);
      end
      if (i == 1) begin
        n_cmp++;
        if (bus.if_id_instr !== 32'h8001060A) begin
          n_bad++;
          $display("FAIL first_instr: got %h want 8001060a", bus.if_id_instr);
        end
      end
    end
    n_cmp++;
    if (bus.fetch_done !== 1'b1 || bus.rom_pc !== 32'd48) begin
      n_bad++;
      $display("FAIL end_of_image: done=%b pc=%h, want 1 00000030", bus.fetch_done, bus.rom_pc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.if_id_valid !== 1'b0 || bus.rom_pc !== 32'd48 || bus.fetch_count !== 16'd12 || bus.if_id_instr !== 32'd0) begin
        n_bad++;
        $display("FAIL past_end_%0d: valid=%b pc=%h cnt=%0d instr=%h, want 0 00000030 12 0",
                 i, bus.if_id_valid, bus.rom_pc, bus.fetch_count, bus.if_id_instr);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.rom_pc !== 32'd8 || bus.if_id_pc_plus4 !== 32'd8 || bus.if_id_instr !== rom[1] ||
          bus.if_id_valid !== 1'b1 || bus.fetch_count !== 16'd2) begin
        n_bad++;
        $display("FAIL stall_%0d: pc=%h pc4=%h instr=%h valid=%b cnt=%0d, want 8 8 %h 1 2",
                 i, bus.rom_pc, bus.if_id_pc_plus4, bus.if_id_instr, bus.if_id_valid, bus.fetch_count, rom[1]);
      end
    end
    bus.stall = 0;
    step();
    n_cmp++;
    if (bus.if_id_pc_plus4 !== 32'd12 || bus.if_id_instr !== rom[2] || bus.fetch_count !== 16'd3) begin
      n_bad++;
      $display("FAIL stall_release: pc4=%h instr=%h cnt=%0d, want c %h 3", bus.if_id_pc_plus4, bus.if_id_instr, bus.fetch_count, rom[2]);
    end
  endtask

  task automatic test_branch_beats_stall();
    do_reset();
    step(); step();
    bus.branch_taken = 1; bus.branch_target = 32'd36; bus.stall = 1;
    step();
    idle_inputs();
    n_cmp++;
    if (bus.rom_pc !== 32'd36 || bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'd0) begin
      n_bad++;
      $display("FAIL branch_stall: pc=%h valid=%b instr=%h, want 24 0 0", bus.rom_pc, bus.if_id_valid, bus.if_id_instr);
    end
    step();
    n_cmp++;
    if (bus.if_id_pc_plus4 !== 32'd40 || bus.if_id_instr !== 32'h80010400 || bus.if_id_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL branch_target_fetch: pc4=%h instr=%h valid=%b, want 28 80010400 1",
               bus.if_id_pc_plus4, bus.if_id_instr, bus.if_id_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    repeat (4) step();
    bus.flush = 1;
    step();
    bus.flush = 0;
    n_cmp++;
    if (bus.if_id_instr !== 32'd0 || bus.if_id_valid !== 1'b0 || bus.rom_pc !== 32'd20 ||
        bus.fetch_count !== 16'd4 || bus.if_id_pc_plus4 !== 32'd20) begin
      n_bad++;
      $display("FAIL flush: instr=%h valid=%b pc=%h cnt=%0d pc4=%h, want 0 0 14 4 14",
               bus.if_id_instr, bus.if_id_valid, bus.rom_pc, bus.fetch_count, bus.if_id_pc_plus4);
    end
  endtask

  task automatic test_align_resume();
    do_reset();
    repeat (13) step();
    bus.branch_taken = 1; bus.branch_target = 32'h00000007;
    step();
    idle_inputs();
    n_cmp++;
    if (bus.rom_pc !== 32'd4 || bus.fetch_done !== 1'b0) begin
      n_bad++;
      $display("FAIL align: pc=%h done=%b, want 4 0", bus.rom_pc, bus.fetch_done);
    end
    step();
    n_cmp++;
    if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_plus4 !== 32'd8 || bus.if_id_instr !== rom[1] || bus.fetch_count !== 16'd13) begin
      n_bad++;
      $display("FAIL resume: valid=%b pc4=%h instr=%h cnt=%0d, want 1 8 %h 13",
               bus.if_id_valid, bus.if_id_pc_plus4, bus.if_id_instr, bus.fetch_count, rom[1]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (7) step();
    n_cmp++;
    if (bus.rom_pc !== 32'd28 || bus.if_id_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_async: pc=%h valid=%b, want 1c 1", bus.rom_pc, bus.if_id_valid);
    end
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if (bus.rom_pc !== 32'd0 || bus.if_id_pc_plus4 !== 32'd0 || bus.if_id_instr !== 32'd0 ||
        bus.if_id_valid !== 1'b0 || bus.fetch_count !== 16'd0) begin
      n_bad++;
      $display("FAIL async_reset: pc=%h pc4=%h instr=%h valid=%b cnt=%0d, want all zero",
               bus.rom_pc, bus.if_id_pc_plus4, bus.if_id_instr, bus.if_id_valid, bus.fetch_count);
    end
    bus.branch_taken = 1; bus.branch_target = 32'd40; bus.flush = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.rom_pc !== 32'd0 || bus.if_id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_override: pc=%h valid=%b, want 0 0", bus.rom_pc, bus.if_id_valid);
    end
    do_reset();
    step();
    n_cmp++;
    if (bus.if_id_pc_plus4 !== 32'd4 || bus.if_id_instr !== rom[0] || bus.if_id_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_fetch: pc4=%h instr=%h valid=%b, want 4 %h 1", bus.if_id_pc_plus4, bus.if_id_instr, bus.if_id_valid, rom[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.stall = ($urandom_range(3) == 0);
      bus.flush = ($urandom_range(9) == 0);
      bus.branch_taken = ($urandom_range(9) == 0);
      bus.branch_target = ($urandom_range(19) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(63));
      step();
      n_cmp++;
      if (bus.rom_pc !== m_pc || bus.if_id_pc_plus4 !== m_pc4 || bus.if_id_instr !== m_instr ||
          bus.if_id_valid !== m_valid || bus.fetch_count !== 16'(m_cnt) || bus.fetch_done !== (m_pc >= 32'd48)) begin
        n_bad++;
        $display("FAIL random_%0d: pc=%h pc4=%h instr=%h valid=%b cnt=%0d done=%b, want %h %h %h %b %0d %b",
                 i, bus.rom_pc, bus.if_id_pc_plus4, bus.if_id_instr, bus.if_id_valid, bus.fetch_count, bus.fetch_done,
                 m_pc, m_pc4, m_instr, m_valid, m_cnt, m_pc >= 32'd48);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rom[0] = 32'h8001060A; rom[1] = 32'h20080005; rom[2] = 32'h20090007; rom[3] = 32'h01095020;
    rom[4] = 32'hAC0A0010; rom[5] = 32'h8C0B0010; rom[6] = 32'h016A6022; rom[7] = 32'h11800002;
    rom[8] = 32'h3C0D1234; rom[9] = 32'h80010400; rom[10] = 32'h08000003; rom[11] = 32'h00000020;
    #1;
    test_reset();
    test_straight_run();
    test_stall();
    test_branch_beats_stall();
    test_flush();
    test_align_resume();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch (IF) pipeline stage of the MIPS core: it owns the program counter, drives the PC into the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register. It handles hazard-unit stalls, branch redirects and flushes from later stages, and stops fetching cleanly at the end of the loaded program image. It sits between the instruction ROM and the decode stage.

## Interface
- RESET_PC, 32'd0, PC value loaded on reset.
- END_PC, 32'd48, first byte address beyond the program image; fetch stops at or above it.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- flush  in  1  squash the IF/ID contents to a bubble.
- branch_taken  in  1  redirect fetch to branch_target.
- branch_target  in  32  redirect byte address.
- rom_pc  out  32  address to ROM PC input.
- rom_instr  in  32  ROM Instruction output (combinational, same cycle).
- if_id_pc_plus4  out  32  registered PC+4 of the captured instruction.
- if_id_instr  out  32  registered instruction word.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_done  out  1  PC is at or beyond END_PC.
- fetch_count  out  16  number of valid instructions delivered to IF/ID.

## Operation
- pc register; rom_pc = pc, combinational. fetch_done = (pc >= END_PC), unsigned compare, combinational.
- Per-edge priority, highest first:
  1. branch_taken: pc <= {branch_target[31:2], 2'b00}; IF/ID loads a bubble. This overrides stall.
  2. flush, without branch_taken: IF/ID loads a bubble; pc advances as in case 4, or holds if fetch_done. This overrides stall.
  3. stall: pc and all IF/ID registers hold. fetch_count holds.
  4. Otherwise, if fetch_done = 0: pc <= pc+4; IF/ID <= {pc+4, rom_instr, valid=1}.
  5. Otherwise, with fetch_done = 1: pc holds; IF/ID loads a bubble.
- Bubble contents: if_id_instr = 32'h0000_0000 (NOP), if_id_valid = 0, and if_id_pc_plus4 = pc+4 of the slot.
- fetch_count increments only on edges where case 4 fires. It saturates at 16'hFFFF.
- pc+4 wraps modulo 2^32. A branch to a target below END_PC after fetch_done resumes fetching normally.
- rom_instr is ignored whenever fetch_done = 1, because the ROM output is undefined beyond the image.

## Timing
- Reset, asynchronous on rst_n low: pc = RESET_PC, if_id_pc_plus4 = 0, if_id_instr = 0, if_id_valid = 0, fetch_count = 0. fetch_done follows pc combinationally.
- Reset asserted mid-operation takes effect immediately, independent of clk. It overrides stall, flush and branch_taken.
- Latency from pc to IF/ID is one cycle. The first rising edge after rst_n deasserts captures the instruction at RESET_PC.
- Branch penalty is one bubble. On the edge after branch_taken, pc = target and IF/ID is invalid. On the following edge, IF/ID holds the target instruction.
- All control inputs are sampled on the rising clk edge. The design has no combinational path from inputs to if_id_* outputs.

## Test plan
- **Straight run:** reset, then 12 free edges. IF/ID delivers pc_plus4 = 4, 8, ..., 48; the first if_id_instr = 32'h8001060A. After the 12th edge, fetch_done = 1 and pc = 48. On the 13th and later edges, if_id_valid = 0, pc holds at 48, and fetch_count stays at 12.
- **Stall:** stall = 1 for 3 cycles while pc = 8. rom_pc stays 8, IF/ID keeps pc_plus4 = 8 with its instruction, and fetch_count is unchanged. On release, the next edge captures the word at address 8 with pc_plus4 = 12.
- **Branch beats stall:** branch_taken = 1, branch_target = 36, stall = 1, all on the same edge. Next: pc = 36, if_id_valid = 0. The following edge gives if_id_pc_plus4 = 40 and if_id_instr = 32'h80010400.
- **Flush alone at pc = 16:** IF/ID becomes a bubble (instr 0, valid 0) and pc = 20. fetch_count does not increment.
- **Target alignment and resume:** from fetch_done, branch_target = 32'h00000007. Next pc = 4, fetch_done = 0, and fetching resumes.
- **Async reset:** drop rst_n between edges at pc = 28 with valid IF/ID contents. All outputs immediately take their reset values. The first edge after release captures address 0.
